// File: rtl/dbus_banked_dmem_if.sv
// Bundled core-side data-bus signals for dbus_banked_dmem: per-core packed
// request fields toward the memory, plus the read results and stalls it returns.
interface dbus_banked_dmem_if #(
  parameter int NCORES = 2,
  parameter int ADDRW  = 12
);
  logic [NCORES-1:0]       re;
  logic [NCORES-1:0]       we;
  logic [ADDRW*NCORES-1:0] addr;
  logic [32*NCORES-1:0]    wdata;
  logic [4*NCORES-1:0]     wstrb;
  logic [NCORES-1:0]       is_lr;
  logic [NCORES-1:0]       is_sc;
  logic [32*NCORES-1:0]    rdata;
  logic [NCORES-1:0]       stall;

  modport master (
    output re, we, addr, wdata, wstrb, is_lr, is_sc,
    input  rdata, stall
  );

  modport slave (
    input  re, we, addr, wdata, wstrb, is_lr, is_sc,
    output rdata, stall
  );
endinterface

// File: rtl/dbus_banked_dmem.sv
// Multi-core data memory: word-interleaved single-port banks, per-bank round-robin
// arbitration. Define DMEM_LRSC_EN to add per-core LR/SC reservations.
module dbus_banked_dmem #(
  parameter int NCORES = 2,
  parameter int NBANKS = 2,
  parameter int ADDRW  = 12
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NCORES-1:0]       re_packed_i,
  input  logic [NCORES-1:0]       we_packed_i,
  input  logic [ADDRW*NCORES-1:0] addr_packed_i,
  input  logic [32*NCORES-1:0]    wdata_packed_i,
  input  logic [4*NCORES-1:0]     wstrb_packed_i,
  input  logic [NCORES-1:0]       is_lr_packed_i,
  input  logic [NCORES-1:0]       is_sc_packed_i,
  output logic [32*NCORES-1:0]    rdata_packed_o,
  output logic [NCORES-1:0]       stall_packed_o
);

  localparam int LOG2B = (NBANKS > 1) ? $clog2(NBANKS) : 0;
  localparam int BW    = (NBANKS > 1) ? LOG2B : 1;
  localparam int ROWW  = ADDRW - LOG2B;
  localparam int DEPTH = 1 << ROWW;
  localparam int PTRW  = (NCORES > 1) ? $clog2(NCORES) : 1;

  // Per-core request view
  logic [ADDRW-1:0] addr      [NCORES];
  logic [31:0]      wdata     [NCORES];
  logic [3:0]       wstrb     [NCORES];
  logic [BW-1:0]    core_bank [NCORES];
  logic [ROWW-1:0]  core_row  [NCORES];
  logic [NCORES-1:0] req, is_rd, is_wr, sc_ok, wr_ok, gnt, wr_commit;

  // Per-bank arbitration and port view
  logic [PTRW-1:0]  ptr_q     [NBANKS];
  logic [PTRW-1:0]  ptr_d     [NBANKS];
  logic [PTRW-1:0]  gnt_core  [NBANKS];
  logic [NBANKS-1:0] bank_act, bank_rd, bank_wr;
  logic [ROWW-1:0]  bank_row  [NBANKS];
  logic [31:0]      bank_wdata[NBANKS];
  logic [3:0]       bank_wstrb[NBANKS];
  logic [31:0]      bank_dout [NBANKS];

  // Per-core read-result tracking
  logic [NCORES-1:0] live_q;
  logic [BW-1:0]     live_bank_q [NCORES];
  logic [31:0]       hold_q      [NCORES];

  // Holding reset low masks every request, which blocks grants, stalls and writes.
  always_comb begin
    for (int c = 0; c < NCORES; c++) begin
      addr[c]      = addr_packed_i[ADDRW*c +: ADDRW];
      wdata[c]     = wdata_packed_i[32*c +: 32];
      wstrb[c]     = wstrb_packed_i[4*c +: 4];
      core_bank[c] = BW'(addr[c] & ADDRW'(NBANKS - 1));
      core_row[c]  = ROWW'(addr[c] >> LOG2B);
      req[c]       = (re_packed_i[c] | we_packed_i[c]) & rst_ni;
      is_wr[c]     = we_packed_i[c] & rst_ni;
      is_rd[c]     = re_packed_i[c] & ~we_packed_i[c] & rst_ni;
      wr_ok[c]     = is_wr[c] & (~is_sc_packed_i[c] | sc_ok[c]);
    end
  end

  // Each bank scans cores starting at its pointer; first requester wins.
  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default before any branch, so no latch is inferred.
  always_comb begin
    int idx;
    idx      = 0;
    gnt      = '0;
    bank_act = '0;
    for (int b = 0; b < NBANKS; b++) begin
      gnt_core[b] = '0;
      for (int i = 0; i < NCORES; i++) begin
        idx = (int'(ptr_q[b]) + i) % NCORES;
        if (!bank_act[b] && req[idx] && core_bank[idx] == BW'(b)) begin
          bank_act[b] = 1'b1;
          gnt_core[b] = PTRW'(idx);
          gnt[idx]    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int b = 0; b < NBANKS; b++) begin
      bank_rd[b]    = bank_act[b] & is_rd[gnt_core[b]];
      bank_wr[b]    = bank_act[b] & wr_ok[gnt_core[b]];
      bank_row[b]   = core_row[gnt_core[b]];
      bank_wdata[b] = wdata[gnt_core[b]];
      bank_wstrb[b] = wstrb[gnt_core[b]];
      ptr_d[b]      = (gnt_core[b] == PTRW'(NCORES - 1)) ? '0 : gnt_core[b] + 1'b1;
    end
  end

  assign wr_commit      = gnt & wr_ok;
  assign stall_packed_o = req & ~gnt;

  // NOTE: clocked state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < NBANKS; b++) ptr_q[b] <= '0;
    end else begin
      for (int b = 0; b < NBANKS; b++) begin
        if (bank_act[b]) ptr_q[b] <= ptr_d[b];
      end
    end
  end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic [31:0] mem [DEPTH];
    logic [31:0] dout_q;

    // NOTE: storage and its read register carry no reset so the array maps
    // onto block RAM; consumers mask dout_q until a read has been granted.
    always_ff @(posedge clk_i) begin
      if (bank_wr[b]) begin
        for (int k = 0; k < 4; k++) begin
          if (bank_wstrb[b][k]) mem[bank_row[b]][8*k +: 8] <= bank_wdata[b][8*k +: 8];
        end
      end else if (bank_rd[b]) begin
        dout_q <= mem[bank_row[b]];
      end
    end

    assign bank_dout[b] = dout_q;
  end

`ifdef DMEM_LRSC_EN
  logic [NCORES-1:0] resv_valid_q;
  logic [ADDRW-1:0]  resv_addr_q [NCORES];

  always_comb begin
    for (int c = 0; c < NCORES; c++) begin
      sc_ok[c] = resv_valid_q[c] && (resv_addr_q[c] == addr[c]);
    end
  end

  // Any committed store to a reserved word kills that reservation for every core.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resv_valid_q <= '0;
      for (int c = 0; c < NCORES; c++) resv_addr_q[c] <= '0;
    end else begin
      for (int c = 0; c < NCORES; c++) begin
        if (gnt[c] && is_rd[c] && is_lr_packed_i[c]) begin
          resv_valid_q[c] <= 1'b1;
          resv_addr_q[c]  <= addr[c];
        end
        if (gnt[c] && is_wr[c] && is_sc_packed_i[c]) resv_valid_q[c] <= 1'b0;
        for (int k = 0; k < NCORES; k++) begin
          if (wr_commit[k] && resv_addr_q[c] == addr[k]) resv_valid_q[c] <= 1'b0;
        end
      end
    end
  end
`else
  logic unused_lr;
  assign unused_lr = ^is_lr_packed_i;
  assign sc_ok     = '1;
`endif

  // A core's result stays live on its bank's output register until another
  // read of that bank would overwrite it; then it is copied into hold_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      live_q <= '0;
      for (int c = 0; c < NCORES; c++) begin
        live_bank_q[c] <= '0;
        hold_q[c]      <= '0;
      end
    end else begin
      for (int c = 0; c < NCORES; c++) begin
        if (gnt[c] && is_rd[c]) begin
          live_q[c]      <= 1'b1;
          live_bank_q[c] <= core_bank[c];
        end else if (gnt[c] && is_wr[c] && is_sc_packed_i[c]) begin
          live_q[c] <= 1'b0;
          hold_q[c] <= {31'b0, ~sc_ok[c]};
        end else if (live_q[c] && bank_rd[live_bank_q[c]]) begin
          live_q[c] <= 1'b0;
          hold_q[c] <= bank_dout[live_bank_q[c]];
        end
      end
    end
  end

  always_comb begin
    rdata_packed_o = '0;
    for (int c = 0; c < NCORES; c++) begin
      rdata_packed_o[32*c +: 32] = live_q[c] ? bank_dout[live_bank_q[c]] : hold_q[c];
    end
  end

endmodule

// File: doc/dbus_banked_dmem.md
DBUS_BANKED_DMEM -- requirements
Module: dbus_banked_dmem

Interface
REQ-001 SHALL have parameter NCORES, default 2: number of requesting cores (1..8).
REQ-002 SHALL have parameter NBANKS, default 2: number of word-interleaved banks (power of two, 1..8).
REQ-003 SHALL have parameter ADDRW, default 12: per-core word-address width (total capacity 2^ADDRW words).
REQ-004 SHALL have ports clk_i in 1 (clock) and rst_ni in 1 (asynchronous active-low reset), listed in that order before all other ports.
REQ-005 SHALL have ports re_packed_i in NCORES (read request) and we_packed_i in NCORES (write request), one bit per core.
REQ-006 SHALL have ports addr_packed_i in ADDRW*NCORES (word address, core c at [ADDRW*c +: ADDRW]), wdata_packed_i in 32*NCORES, and wstrb_packed_i in 4*NCORES (byte enables).
REQ-007 SHALL have ports is_lr_packed_i in NCORES (read is load-reserved) and is_sc_packed_i in NCORES (write is store-conditional).
REQ-008 SHALL have ports rdata_packed_o out 32*NCORES (per-core read/SC result) and stall_packed_o out NCORES (request not accepted this cycle).

Function
REQ-009 Bank = addr[log2(NBANKS)-1:0]; bank row = remaining upper address bits; NBANKS=1 SHALL map every address to bank 0.
REQ-010 Request(c) = re|we; if both set, SHALL be treated as a write.
REQ-011 Each bank SHALL grant at most one request per cycle by round-robin; after granting core k, highest priority moves to core (k+1) mod NCORES; an idle bank keeps its pointer.
REQ-012 stall(c) SHALL be combinational, = request(c) & !granted(c); a stalled core holds its request unchanged.
REQ-013 Requests to different banks SHALL all be granted in the same cycle.
REQ-014 Granted write SHALL update only the bytes enabled by wstrb, at the clock edge ending the grant cycle.
REQ-015 Granted read SHALL load rdata(c) on the next clock edge (1-cycle latency) with the pre-write contents of that word; rdata(c) SHALL hold until the core's next granted read or SC.
REQ-016 Bank storage SHALL be synchronous single-port BRAM-inferable, not reset.

Reset
REQ-017 rst_ni low SHALL asynchronously clear all round-robin pointers to core 0, all reservations, and all rdata outputs to 0.
REQ-018 While rst_ni is low, stall_packed_o SHALL be 0, no write SHALL occur, and any in-flight read result SHALL be discarded.
REQ-019 After rst_ni rises, the first grant in each bank SHALL follow the pointer-at-core-0 order.

Configuration
REQ-020 Macro DMEM_LRSC_EN defined: per-core reservation (valid + word address); granted LR sets it to the LR address; any granted write or successful SC to word A by any core SHALL clear every reservation on A.
REQ-021 With DMEM_LRSC_EN, granted SC SHALL write and return rdata 0 if its core holds a valid reservation on that address, else SHALL not write and return rdata 1; the SC core's reservation SHALL be cleared in either case.
REQ-022 Without DMEM_LRSC_EN, no reservation storage SHALL exist; LR SHALL act as a plain read; SC SHALL always write and return rdata 0.

Verification
REQ-023 NCORES=2, NBANKS=2: core0 writes 0xDEADBEEF, strb 0xF to word 4, then reads word 4 -> no stall, rdata0 = 0xDEADBEEF one cycle after the read grant.
REQ-024 Word 0 = 0; core0 writes 0xAABBCCDD with strb 0x2, then reads word 0 -> rdata0 = 0x0000CC00.
REQ-025 After reset, both cores read bank 0 (words 2, 6) together -> core0 granted, stall1 = 1 for exactly one cycle; a repeated conflict grants core1 first.
REQ-026 Cores read words 2 and 3 together -> stall_packed_o = 0, both rdata valid next cycle.
REQ-027 DMEM_LRSC_EN: core0 LR word 8; core1 writes 0x11 to word 8; core0 SC 0x22 to word 8 -> rdata0 = 1, word 8 = 0x11; core0 LR/SC 0x05 without intervening write -> rdata0 = 0, word 8 = 0x05; immediate second SC -> rdata0 = 1.
REQ-028 rst_ni pulsed low while core1 is stalled on a conflict -> stall_packed_o = 0 and rdata_packed_o = 0 immediately; no write to the contested word.
